// File: rtl/pci_mailbox_pkg.sv
// rtl/pci_mailbox_pkg.sv - register map, bit positions and irq source indices for the PCI Wishbone mailbox
package pci_mailbox_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY = 16;
    localparam int ST_TX_FULL  = 17;
    localparam int ST_RX_EMPTY = 18;
    localparam int ST_RX_FULL  = 19;
    localparam int ST_OVF      = 24;
    localparam int ST_UNF      = 25;

    localparam int CTRL_TX_FLUSH = 8;
    localparam int CTRL_RX_FLUSH = 9;

    localparam int IRQ_RX_NONEMPTY = 0;
    localparam int IRQ_TX_EMPTY    = 1;
    localparam int IRQ_OVF         = 2;
    localparam int IRQ_UNF         = 3;
    localparam int IRQ_W           = 4;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/pci_wb_mailbox_if.sv
// rtl/pci_wb_mailbox_if.sv - Wishbone classic bus between the PCI target core and the mailbox
interface pci_wb_mailbox_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    logic        wb_irq_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o, wb_irq_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o, wb_irq_o
    );
endinterface

// File: rtl/mailbox_fifo.sv
// rtl/mailbox_fifo.sv - word FIFO with show-ahead head, count and flush
module mailbox_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [31:0]   data_i,
    output logic [31:0]   data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_q [DEPTH];
    logic          push_ok, pop_ok;

    // Full/empty come from the count registered before the edge, so a push
    // into a full FIFO is dropped even when a pop happens in the same cycle.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pci_wb_mailbox.sv
// rtl/pci_wb_mailbox.sv - Wishbone mailbox with TX/RX FIFOs, STATUS/CTRL and INTA
// Optional interrupt logic: PCI_MAILBOX_IRQ_EN
module pci_wb_mailbox
    import pci_mailbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pci_wb_mailbox_if.slave       wb,
    output logic [31:0]           tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [31:0]           rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_e        state_q, state_d;
    logic             access, wr_acc, rd_acc;
    logic [1:0]       reg_sel;
    logic             tx_push, rx_pop, st_wr, ctrl_wr, tx_flush, rx_flush;
    logic [CW-1:0]    tx_count, rx_count;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [31:0]      rx_head;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [31:0]      dat_q, rdata, status;
    logic [IRQ_W-1:0] irq_en, src;

    assign access  = wb.wb_cyc_i & wb.wb_stb_i & (state_q == WB_IDLE);
    assign wr_acc  = access & wb.wb_we_i;
    assign rd_acc  = access & ~wb.wb_we_i;
    assign reg_sel = wb.wb_adr_i[3:2];

    assign tx_push  = wr_acc & (reg_sel == REG_TXDATA) & (wb.wb_sel_i == 4'hF);
    assign rx_pop   = rd_acc & (reg_sel == REG_RXDATA);
    assign st_wr    = wr_acc & (reg_sel == REG_STATUS);
    assign ctrl_wr  = wr_acc & (reg_sel == REG_CTRL);
    assign tx_flush = ctrl_wr & wb.wb_dat_i[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr & wb.wb_dat_i[CTRL_RX_FLUSH];

    always_comb begin
        state_d = WB_IDLE;
        if (access) state_d = WB_ACK;
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    mailbox_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push_i(tx_push), .pop_i(tx_ready), .flush_i(tx_flush),
        .data_i(wb.wb_dat_i), .data_o(tx_data),
        .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
    );

    mailbox_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push_i(rx_valid), .pop_i(rx_pop), .flush_i(rx_flush),
        .data_i(rx_data), .data_o(rx_head),
        .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // A new event outranks a same-cycle write-1-to-clear.
    always_comb begin
        ovf_d = (ovf_q & ~(st_wr & wb.wb_dat_i[ST_OVF])) | (tx_push & tx_full);
        unf_d = (unf_q & ~(st_wr & wb.wb_dat_i[ST_UNF])) | (rx_pop & rx_empty);
    end

    always_comb begin
        status              = '0;
        status[7:0]         = 8'(tx_count);
        status[15:8]        = 8'(rx_count);
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVF]      = ovf_q;
        status[ST_UNF]      = unf_q;
        rdata = '0;
        case (reg_sel)
            REG_RXDATA: rdata = rx_head;
            REG_STATUS: rdata = status;
            REG_CTRL:   rdata = 32'(irq_en);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (access) dat_q <= rdata;
        end
    end

    assign wb.wb_ack_o = (state_q == WB_ACK);
    assign wb.wb_dat_o = dat_q;

    assign src[IRQ_RX_NONEMPTY] = ~rx_empty;
    assign src[IRQ_TX_EMPTY]    = tx_empty;
    assign src[IRQ_OVF]         = ovf_q;
    assign src[IRQ_UNF]         = unf_q;

`ifdef PCI_MAILBOX_IRQ_EN
    logic [IRQ_W-1:0] irq_en_q;
    logic             irq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wb.wb_dat_i[IRQ_W-1:0];
            irq_q <= |(src & irq_en_q);
        end
    end

    assign irq_en      = irq_en_q;
    assign wb.wb_irq_o = irq_q;
`else
    assign irq_en      = '0;
    assign wb.wb_irq_o = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], src};

endmodule

// File: tb/tb_pci_wb_mailbox.sv
// tb/tb_pci_wb_mailbox.sv - self-checking bench for pci_wb_mailbox with a queue-based reference model
module tb_pci_wb_mailbox;
    localparam int DEPTH = 8;
`ifdef PCI_MAILBOX_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif
    localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_ST = 2'd2, A_CT = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    always #5 clk = ~clk;

    pci_wb_mailbox_if wb ();

    pci_wb_mailbox #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wb(wb),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    logic        m_ovf, m_unf;
    logic [3:0]  m_en;
    int          total, bad;

    function automatic void mdl_reset();
        m_tx.delete(); m_rx.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_en = 4'h0;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'h0;
        s[7:0]  = 8'(m_tx.size());
        s[15:8] = 8'(m_rx.size());
        s[16] = (m_tx.size() == 0);
        s[17] = (m_tx.size() == DEPTH);
        s[18] = (m_rx.size() == 0);
        s[19] = (m_rx.size() == DEPTH);
        s[24] = m_ovf;
        s[25] = m_unf;
        return s;
    endfunction

    function automatic logic exp_irq();
        logic [3:0] s;
        s = {m_unf, m_ovf, m_tx.size() == 0, m_rx.size() != 0};
        return IRQ_BUILD && ((s & m_en) != 4'h0);
    endfunction

    function automatic void mdl_write(logic [1:0] r, logic [31:0] d, logic [3:0] sel);
        if (r == A_TX && sel == 4'hF) begin
            if (m_tx.size() == DEPTH) m_ovf = 1'b1;
            else m_tx.push_back(d);
        end else if (r == A_ST) begin
            if (d[24]) m_ovf = 1'b0;
            if (d[25]) m_unf = 1'b0;
        end else if (r == A_CT) begin
            if (IRQ_BUILD) m_en = d[3:0];
            if (d[8]) m_tx.delete();
            if (d[9]) m_rx.delete();
        end
    endfunction

    function automatic logic [31:0] mdl_read(logic [1:0] r);
        case (r)
            A_RX: begin
                if (m_rx.size() == 0) begin
                    m_unf = 1'b1;
                    return 32'h0;
                end
                return m_rx.pop_front();
            end
            A_ST:    return exp_status();
            A_CT:    return {28'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    // Starts and ends on a falling edge; ack_after is sampled one cycle after the ack.
    task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd,
                           output int cycles, output logic ack_after);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = r;
        wb.wb_adr_i = a; wb.wb_dat_i = d; wb.wb_sel_i = sel;
        wb.wb_we_i = we; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        cycles = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o === 1'b1) begin
                cycles = i;
                break;
            end
        end
        rd = wb.wb_dat_o;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge clk);
        ack_after = wb.wb_ack_o;
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel,
                            output int cy, output logic aa);
        logic [31:0] rd;
        wb_xfer(1'b1, r, d, sel, rd, cy, aa);
        mdl_write(r, d, sel);
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] rd, output logic [31:0] ex,
                           output int cy, output logic aa);
        ex = mdl_read(r);
        wb_xfer(1'b0, r, $urandom, 4'hF, rd, cy, aa);
    endtask

    task automatic local_rx_push(input logic [31:0] d, output logic rdy, output logic rdy_exp);
        rx_valid = 1'b1; rx_data = d;
        rdy = rx_ready;
        rdy_exp = (m_rx.size() < DEPTH);
        @(negedge clk);
        rx_valid = 1'b0;
        if (rdy_exp) m_rx.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({wb.wb_ack_o, wb.wb_irq_o, tx_valid, rx_ready} !== 4'b0001) begin
            bad++; $display("FAIL reset_ctl got=%b exp=0001", {wb.wb_ack_o, wb.wb_irq_o, tx_valid, rx_ready}); end
        total++; if ({wb.wb_dat_o, tx_data} !== 64'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {wb.wb_dat_o, tx_data}); end
        reset = 1'b1;
        mdl_reset();
        @(negedge clk);
    endtask

    task automatic test_tx_basic();
        logic [31:0] rd, ex; int cy; logic aa;
        wb_write(A_TX, 32'hDEADBEEF, 4'hF, cy, aa);
        total++; if (cy !== 1 || aa !== 1'b0) begin
            bad++; $display("FAIL ack_timing got=%0d/%b exp=1/0", cy, aa); end
        wb_write(A_TX, 32'h12345678, 4'hF, cy, aa);
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== ex || rd !== 32'h0004_0002) begin
            bad++; $display("FAIL tx2_status got=%h exp=%h", rd, ex); end
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== m_tx[0]) begin
                bad++; $display("FAIL tx_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, m_tx[0]); end
            @(negedge clk);
            void'(m_tx.pop_front());
        end
        total++; if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd, ex; int cy; logic aa;
        wb_write(A_TX, $urandom, 4'h7, cy, aa);
        for (int i = 0; i <= DEPTH; i++) wb_write(A_TX, $urandom, 4'hF, cy, aa);
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== ex || rd[24] !== 1'b1 || rd[7:0] !== 8'(DEPTH)) begin
            bad++; $display("FAIL ovf_status got=%h exp=%h", rd, ex); end
        total++; if (tx_data !== m_tx[0]) begin
            bad++; $display("FAIL ovf_head got=%h exp=%h", tx_data, m_tx[0]); end
        wb_write(A_ST, 32'h0100_0000, 4'hF, cy, aa);
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== ex || rd[24] !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got=%h exp=%h", rd, ex); end
        wb_write(A_CT, 32'h100, 4'hF, cy, aa);
    endtask

    task automatic test_rx_irq();
        logic [31:0] rd, ex; int cy; logic aa, rdy, rdy_exp;
        local_rx_push(32'hA5A5A5A5, rdy, rdy_exp);
        wb_write(A_CT, 32'h1, 4'hF, cy, aa);
        total++; if (wb.wb_irq_o !== exp_irq() || wb.wb_irq_o !== IRQ_BUILD) begin
            bad++; $display("FAIL irq_rx got=%b exp=%b", wb.wb_irq_o, exp_irq()); end
        wb_read(A_RX, rd, ex, cy, aa);
        total++; if (rd !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL rx_read got=%h exp=a5a5a5a5", rd); end
        total++; if (wb.wb_irq_o !== 1'b0) begin
            bad++; $display("FAIL irq_rx_clear got=%b exp=0", wb.wb_irq_o); end
        wb_read(A_RX, rd, ex, cy, aa);
        total++; if (rd !== 32'h0) begin
            bad++; $display("FAIL rx_empty_read got=%h exp=0", rd); end
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== ex || rd[25] !== 1'b1) begin
            bad++; $display("FAIL unf_status got=%h exp=%h", rd, ex); end
        wb_write(A_CT, 32'h8, 4'hF, cy, aa);
        total++; if (wb.wb_irq_o !== exp_irq()) begin
            bad++; $display("FAIL irq_unf got=%b exp=%b", wb.wb_irq_o, exp_irq()); end
        wb_write(A_ST, 32'h0200_0000, 4'hF, cy, aa);
        wb_write(A_CT, 32'h0, 4'hF, cy, aa);
        for (int i = 0; i <= DEPTH; i++) begin
            local_rx_push($urandom, rdy, rdy_exp);
            total++; if (rdy !== rdy_exp) begin
                bad++; $display("FAIL rx_ready%0d got=%b exp=%b", i, rdy, rdy_exp); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            wb_read(A_RX, rd, ex, cy, aa);
            total++; if (rd !== ex) begin
                bad++; $display("FAIL rx_fifo%0d got=%h exp=%h", i, rd, ex); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd, ex; int cy; logic aa, rdy, rdy_exp;
        for (int i = 0; i < 3; i++) wb_write(A_TX, $urandom, 4'hF, cy, aa);
        tx_ready = 1'b1;
        wb_write(A_CT, 32'h100, 4'hF, cy, aa);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL tx_flush_valid got=%b exp=0", tx_valid); end
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== ex || rd[7:0] !== 8'h0) begin
            bad++; $display("FAIL tx_flush_status got=%h exp=%h", rd, ex); end
        wb_read(A_CT, rd, ex, cy, aa);
        total++; if (rd !== 32'h0) begin
            bad++; $display("FAIL ctrl_read got=%h exp=0", rd); end
        local_rx_push($urandom, rdy, rdy_exp);
        local_rx_push($urandom, rdy, rdy_exp);
        wb_write(A_CT, 32'h200, 4'hF, cy, aa);
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== ex || rd[15:8] !== 8'h0) begin
            bad++; $display("FAIL rx_flush_status got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks; logic [31:0] ex;
        ex = exp_status();
        wb.wb_adr_i = 32'h8; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            acks[i] = wb.wb_ack_o;
            if (wb.wb_ack_o === 1'b1) begin
                total++; if (wb.wb_dat_o !== ex) begin
                    bad++; $display("FAIL b2b_data got=%h exp=%h", wb.wb_dat_o, ex); end
            end
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        total++; if (acks !== 4'b1010) begin
            bad++; $display("FAIL b2b_ack got=%b exp=1010", acks); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, d; int cy; logic aa, rdy, rdy_exp, v_exp;
        logic [3:0] sel;
        for (int n = 0; n < 150; n++) begin
            cy = 1; aa = 1'b0;
            case ($urandom_range(0, 9))
                0, 1: begin
                    sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                    wb_write(A_TX, $urandom, sel, cy, aa);
                end
                2, 6, 9: begin
                    wb_read(2'($urandom_range(0, 3)), rd, ex, cy, aa);
                    total++; if (rd !== ex) begin
                        bad++; $display("FAIL rnd_read%0d got=%h exp=%h", n, rd, ex); end
                end
                3, 4: begin
                    local_rx_push($urandom, rdy, rdy_exp);
                    total++; if (rdy !== rdy_exp) begin
                        bad++; $display("FAIL rnd_rx_ready%0d got=%b exp=%b", n, rdy, rdy_exp); end
                end
                5: begin
                    v_exp = (m_tx.size() != 0);
                    total++; if (tx_valid !== v_exp || (v_exp && tx_data !== m_tx[0])) begin
                        bad++; $display("FAIL rnd_tx_head%0d got=%b/%h exp=%b", n, tx_valid, tx_data, v_exp); end
                    tx_ready = 1'b1;
                    @(negedge clk);
                    tx_ready = 1'b0;
                    if (v_exp) void'(m_tx.pop_front());
                    @(negedge clk);
                end
                7: wb_write(2'($urandom_range(1, 2)), $urandom, 4'hF, cy, aa);
                default: begin
                    d = $urandom;
                    if ($urandom_range(0, 3) != 0) d[9:8] = 2'b00;
                    wb_write(A_CT, d, 4'hF, cy, aa);
                end
            endcase
            total++; if (cy !== 1 || aa !== 1'b0) begin
                bad++; $display("FAIL rnd_ack%0d got=%0d/%b exp=1/0", n, cy, aa); end
            total++; if (wb.wb_irq_o !== exp_irq()) begin
                bad++; $display("FAIL rnd_irq%0d got=%b exp=%b", n, wb.wb_irq_o, exp_irq()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ex; int cy; logic aa;
        wb_write(A_TX, $urandom, 4'hF, cy, aa);
        wb.wb_adr_i = 32'h0; wb.wb_dat_i = $urandom; wb.wb_sel_i = 4'hF;
        wb.wb_we_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        total++; if ({wb.wb_ack_o, wb.wb_irq_o, tx_valid, rx_ready} !== 4'b0001 || wb.wb_dat_o !== 32'h0) begin
            bad++; $display("FAIL reset_mid got=%b/%h exp=0001/0", {wb.wb_ack_o, wb.wb_irq_o, tx_valid, rx_ready}, wb.wb_dat_o); end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        reset = 1'b1;
        mdl_reset();
        @(negedge clk);
        wb_read(A_ST, rd, ex, cy, aa);
        total++; if (rd !== 32'h0005_0000 || rd !== ex) begin
            bad++; $display("FAIL reset_mid_status got=%h exp=00050000", rd); end
    endtask

    initial begin
        total = 0; bad = 0;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        mdl_reset();
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_irq();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
